// File: rtl/exception_unit.sv
// rtl/exception_unit.sv - exception entry/return controller with link, syndrome and MRS read-back
//
// Optional feature macro: EXC_ERR_EN (adds the ERR register capturing the faulting Instr).
//
// Ports:
//   clk, Reset      core clock; synchronous active-high reset
//   Exc, ERet       exception request / ERET decoded (Exc wins when both are high)
//   EStatus         exception cause, loaded into ESR[3:0]
//   ExtIRQ          raw interrupt level; IrqToDec is its masked copy back to the decoder
//   PC, Instr       PC and instruction word currently in decode
//   MrsSel          MRS source: 00 ELR, 01 ESR, 10 ERR, 11 zero
//   ExcAck          one-cycle acknowledge in ENTER
//   PCSel, ExcPC    fetch redirect: 01 to VECTOR in ENTER, 10 to ELR in RETURN
//   ELR, ESR        exception link / syndrome registers
//   InHandler       high in ENTER and HANDLER
//   MrsData         combinational MRS read data
module exception_unit #(
  parameter int             N      = 64,
  parameter logic [N-1:0]   VECTOR = 'hD8
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          Exc,
  input  logic          ERet,
  input  logic [3:0]    EStatus,
  input  logic          ExtIRQ,
  input  logic [N-1:0]  PC,
  input  logic [31:0]   Instr,
  input  logic [1:0]    MrsSel,
  output logic          IrqToDec,
  output logic          ExcAck,
  output logic [1:0]    PCSel,
  output logic [N-1:0]  ExcPC,
  output logic [N-1:0]  ELR,
  output logic [N-1:0]  ESR,
  output logic          InHandler,
  output logic [N-1:0]  MrsData
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    ENTER   = 2'b01,
    HANDLER = 2'b10,
    RETURN  = 2'b11
  } state_t;

  state_t state, next_state;
  logic [N-1:0] err_data;

  // State register plus the link/syndrome registers it governs.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state     <= RUN;
      ELR       <= '0;
      ESR       <= '0;
      InHandler <= 1'b0;
    end else begin
      state     <= next_state;
      InHandler <= (next_state == ENTER) || (next_state == HANDLER);
      case (state)
        RUN: begin
          if (Exc) begin
            ELR <= PC;
            ESR <= {{(N-4){1'b0}}, EStatus};
          end
        end
        HANDLER: begin
          // Double fault: the original return address is preserved, bit 4
          // records that a nested fault happened, the cause is refreshed.
          if (Exc) begin
            ESR <= {ESR[N-1:5], 1'b1, EStatus};
          end
        end
        RETURN: begin
          ESR <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      RUN:     if (Exc) next_state = ENTER;
      ENTER:   next_state = HANDLER;
      HANDLER: begin
        if (Exc)       next_state = ENTER;
        else if (ERet) next_state = RETURN;
      end
      RETURN:  next_state = RUN;
      default: next_state = RUN;
    endcase
  end

  // Redirect and acknowledge decode purely from the state register, so
  // there is no combinational path from Exc to ExcAck.
  always_comb begin
    PCSel  = 2'b00;
    ExcPC  = '0;
    ExcAck = 1'b0;
    case (state)
      ENTER: begin
        PCSel  = 2'b01;
        ExcPC  = VECTOR;
        ExcAck = 1'b1;
      end
      RETURN: begin
        PCSel = 2'b10;
        ExcPC = ELR;
      end
      default: ;
    endcase
  end

  assign IrqToDec = ExtIRQ & (state == RUN) & ~Reset;

`ifdef EXC_ERR_EN
  logic [N-1:0] err_q;

  always_ff @(posedge clk) begin
    if (Reset) begin
      err_q <= '0;
    end else if ((state == RUN) && Exc) begin
      err_q <= {{(N-32){1'b0}}, Instr};
    end else if (state == RETURN) begin
      err_q <= '0;
    end
  end

  assign err_data = err_q;
`else
  logic unused_instr;
  assign unused_instr = ^Instr;
  assign err_data     = '0;
`endif

  always_comb begin
    MrsData = '0;
    case (MrsSel)
      2'b00:   MrsData = ELR;
      2'b01:   MrsData = ESR;
      2'b10:   MrsData = err_data;
      default: MrsData = '0;
    endcase
  end

endmodule
